// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared RV32I load/store constants, LSU state enum, fault rule
package riscv_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // funct3[1:0] encodes access size for every defined load/store opcode
    function automatic logic access_fault(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] byte_off,
        input logic       out_of_range
    );
        logic undefined;
        logic misaligned;
        undefined  = we ? (funct3 > SW) : ((funct3 == 3'b011) || (funct3 > LHU));
        misaligned = ((funct3[1:0] == 2'b01) && byte_off[0]) ||
                     ((funct3[1:0] == 2'b10) && (byte_off != 2'b00));
        return undefined | misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - load lane select and sign/zero extension
module load_ext
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {byte_off, 3'b000};
        case (funct3)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     result = {24'd0, shifted[7:0]};
            LHU:     result = {16'd0, shifted[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store unit over a byte-lane data array
module dmem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    lsu_state_t  state;
    lsu_state_t  next_state;
    logic [3:0]  wait_cnt;

    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          fault;
    logic          out_of_range;
    logic          commit;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic [31:0]   load_word;
    logic [31:0]   load_data;

    assign accept       = req_valid && (state == IDLE);
    assign word_idx     = cap_addr[AW+1:2];
    assign out_of_range = |cap_addr[31:AW+2];
    assign fault        = access_fault(cap_we, cap_funct3, cap_addr[1:0], out_of_range);
    // reset in the RESP cycle abandons the store as well
    assign commit       = (state == RESP) && cap_we && !fault && !reset;
    assign load_word    = mem[word_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_fault = rsp_valid && fault;
        rsp_rdata = (rsp_valid && !fault && !cap_we) ? load_data : 32'd0;
    end

    // store data is replicated across lanes so the enable alone picks the target bytes
    always_comb begin
        case (cap_funct3[1:0])
            2'b00: begin
                lane_en   = 4'b0001 << cap_addr[1:0];
                lane_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = cap_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = cap_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    load_ext u_load_ext (
        .word     (load_word),
        .byte_off (cap_addr[1:0]),
        .funct3   (cap_funct3),
        .result   (load_data)
    );

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu at WAIT_CYCLES 1, 2 and 0
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_fault  [3];

    int errors = 0;
    int checks = 0;

    // byte-addressed reference memory per instance (256 words = 1024 bytes)
    logic [7:0] mm [3][1024];

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
    );

    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
    );

    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_funct3(req_funct3[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_fault(rsp_fault[2])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 0;
    endfunction

    function automatic void model_access(input int d, input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic fault);
        int size;
        logic undefined;
        logic [31:0] v;
        undefined = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        fault = undefined || (addr % size != 0) || (addr / 4 >= 256);
        rdata = 32'd0;
        if (fault) return;
        if (we) begin
            for (int i = 0; i < size; i++) mm[d][addr[9:0] + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mm[d][addr[9:0] + i]) << (8 * i));
            if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rdata = v;
        end
    endfunction

    task automatic do_access(input int d, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic fault, output int lat);
        int n;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) lat = -1;
        rdata = rsp_rdata[d];
        fault = rsp_fault[d];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_fault[d] !== 1'b0 ||
                rsp_rdata[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got ready=%b valid=%b fault=%b rdata=%h exp 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_fault[d], rsp_rdata[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_word_rw();
        logic [31:0] r, er;
        logic f, ef;
        int lat;
        model_access(0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, er, ef);
        do_access(0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, r, f, lat);
        checks++;
        if (lat !== 2 || f !== 1'b0 || r !== 32'd0) begin
            errors++;
            $display("FAIL sw_0x40 got lat=%0d fault=%b rdata=%h exp lat=2 fault=0 rdata=0", lat, f, r);
        end
        model_access(0, 1'b0, 3'b010, 32'h40, 32'd0, er, ef);
        do_access(0, 1'b0, 3'b010, 32'h40, 32'd0, r, f, lat);
        checks++;
        if (lat !== 2 || f !== 1'b0 || r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_0x40 got lat=%0d fault=%b rdata=%h exp lat=2 fault=0 rdata=deadbeef", lat, f, r);
        end
    endtask

    task automatic test_partial();
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h43, 32'h43, 32'h42, 32'h40};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h00007FEF};
        logic [31:0] r, er;
        logic f, ef;
        int lat;
        model_access(0, 1'b1, 3'b000, 32'h41, 32'h0000007F, er, ef);
        do_access(0, 1'b1, 3'b000, 32'h41, 32'h0000007F, r, f, lat);
        checks++;
        if (f !== 1'b0 || r !== 32'd0) begin
            errors++;
            $display("FAIL sb_0x41 got fault=%b rdata=%h exp fault=0 rdata=0", f, r);
        end
        for (int i = 0; i < 4; i++) begin
            model_access(0, 1'b0, f3s[i], adrs[i], 32'd0, er, ef);
            do_access(0, 1'b0, f3s[i], adrs[i], 32'd0, r, f, lat);
            checks++;
            if (f !== 1'b0 || r !== exps[i] || lat !== 2) begin
                errors++;
                $display("FAIL subword_load f3=%b addr=%h got rdata=%h fault=%b lat=%0d exp rdata=%h fault=0 lat=2",
                         f3s[i], adrs[i], r, f, lat, exps[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b000, 3'b011};
        logic [31:0] adrs [4] = '{32'h42, 32'h45, 32'h400, 32'h40};
        logic [31:0] r, er;
        logic f, ef;
        int lat;
        for (int i = 0; i < 4; i++) begin
            model_access(0, wes[i], f3s[i], adrs[i], 32'hA5A5A5A5, er, ef);
            do_access(0, wes[i], f3s[i], adrs[i], 32'hA5A5A5A5, r, f, lat);
            checks++;
            if (f !== 1'b1 || r !== 32'd0 || lat !== 2) begin
                errors++;
                $display("FAIL fault_case%0d got fault=%b rdata=%h lat=%0d exp fault=1 rdata=0 lat=2", i, f, r, lat);
            end
        end
        do_access(0, 1'b0, 3'b010, 32'h40, 32'd0, r, f, lat);
        checks++;
        if (r !== 32'hDEAD7FEF || f !== 1'b0) begin
            errors++;
            $display("FAIL after_fault_lw got rdata=%h fault=%b exp rdata=dead7fef fault=0", r, f);
        end
    endtask

    task automatic test_hold_valid();
        logic [31:0] r, er;
        logic f, ef;
        int lat, accepts, ready_lo, pulses;
        logic [31:0] seen;
        model_access(1, 1'b1, 3'b010, 32'h20, 32'h5A5AA5A5, er, ef);
        do_access(1, 1'b1, 3'b010, 32'h20, 32'h5A5AA5A5, r, f, lat);
        checks++;
        if (lat !== 3 || f !== 1'b0) begin
            errors++;
            $display("FAIL wait2_sw_latency got lat=%0d fault=%b exp lat=3 fault=0", lat, f);
        end
        model_access(1, 1'b0, 3'b010, 32'h20, 32'd0, er, ef);
        accepts = 0; ready_lo = 0; pulses = 0; seen = 32'd0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 0) begin
                req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010;
                req_addr[1] = 32'h20; req_wdata[1] = 32'd0;
            end
            if (n == 4) req_valid[1] = 1'b0;
            if (req_valid[1] && req_ready[1]) accepts++;
            if (!req_ready[1]) ready_lo++;
            if (rsp_valid[1]) begin
                pulses++;
                seen = rsp_rdata[1];
            end
        end
        checks++;
        if (accepts !== 1 || ready_lo !== 3 || pulses !== 1) begin
            errors++;
            $display("FAIL hold_valid got accepts=%0d ready_low=%0d pulses=%0d exp 1 3 1", accepts, ready_lo, pulses);
        end
        checks++;
        if (seen !== er) begin
            errors++;
            $display("FAIL hold_valid_data got %h exp %h", seen, er);
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] r, er;
        logic f, ef;
        int lat, seen;
        model_access(0, 1'b1, 3'b010, 32'h80, 32'hCAFEF00D, er, ef);
        do_access(0, 1'b1, 3'b010, 32'h80, 32'hCAFEF00D, r, f, lat);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 32'h80; req_wdata[0] = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        seen = rsp_valid[0] ? 1 : 0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight_state got ready=%b valid=%b exp ready=1 valid=0", req_ready[0], rsp_valid[0]);
        end
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_inflight_pulse got %0d rsp_valid cycles exp 0", seen);
        end
        do_access(0, 1'b0, 3'b010, 32'h80, 32'd0, r, f, lat);
        checks++;
        if (r !== 32'hCAFEF00D || f !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight_lw got rdata=%h fault=%b exp rdata=cafef00d fault=0", r, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, er;
        logic ef;
        v = $urandom;
        model_access(2, 1'b1, 3'b010, 32'h10, v, er, ef);
        @(negedge clk);
        checks++;
        if (req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle got ready=%b exp 1", req_ready[2]);
        end
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'b010;
        req_addr[2] = 32'h10; req_wdata[2] = v;
        @(posedge clk);
        @(negedge clk);
        req_we[2] = 1'b0; req_wdata[2] = 32'd0;
        checks++;
        if (rsp_valid[2] !== 1'b1 || req_ready[2] !== 1'b0 || rsp_fault[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sw_resp got valid=%b ready=%b fault=%b exp 1 0 0", rsp_valid[2], req_ready[2], rsp_fault[2]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got ready=%b valid=%b exp 1 0", req_ready[2], rsp_valid[2]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== v || req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lw_resp got valid=%b rdata=%h ready=%b exp 1 %h 0", rsp_valid[2], rsp_rdata[2], req_ready[2], v);
        end
        @(negedge clk);
        checks++;
        if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got ready=%b valid=%b exp 1 0", req_ready[2], rsp_valid[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, w;
        logic f, ef, we;
        logic [2:0] f3;
        int lat;
        int insts [2] = '{0, 2};
        foreach (insts[k]) begin
            int d;
            d = insts[k];
            for (int i = 0; i < 16; i++) begin
                w = $urandom;
                model_access(d, 1'b1, 3'b010, 32'h100 + 32'(4 * i), w, er, ef);
                do_access(d, 1'b1, 3'b010, 32'h100 + 32'(4 * i), w, r, f, lat);
            end
            for (int i = 0; i < 50; i++) begin
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                a  = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                                  : 32'h100 + 32'($urandom_range(0, 63));
                w  = $urandom;
                model_access(d, we, f3, a, w, er, ef);
                do_access(d, we, f3, a, w, r, f, lat);
                checks++;
                if (r !== er || f !== ef || lat !== wait_of(d) + 1) begin
                    errors++;
                    $display("FAIL random inst=%0d we=%b f3=%b addr=%h got rdata=%h fault=%b lat=%0d exp rdata=%h fault=%b lat=%0d",
                             d, we, f3, a, r, f, lat, er, ef, wait_of(d) + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_partial();
        test_faults();
        test_hold_valid();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, data-array depth in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra access-latency cycles (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I load/store funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  formatted load data.
REQ-013 SHALL have port rsp_fault  output  1  access rejected; valid with rsp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when req_valid & req_ready, capturing we/funct3/addr/wdata; then go to WAIT if WAIT_CYCLES > 0, else RESP.
REQ-016 SHALL stay in WAIT exactly WAIT_CYCLES cycles via a down-counter, then go to RESP.
REQ-017 SHALL assert rsp_valid for exactly one cycle in RESP, WAIT_CYCLES+1 cycles after the acceptance edge, then return to IDLE.
REQ-018 SHALL ignore req_valid whenever req_ready = 0; no queuing and no back-pressure on the response.
REQ-019 SHALL fault on misalignment: halfword with addr[0] = 1, or word with addr[1:0] != 0.
REQ-020 SHALL fault when addr[31:2] >= DEPTH_WORDS.
REQ-021 SHALL fault on undefined funct3: loads 011/110/111; stores >= 011.
REQ-022 SHALL, on a faulting access, write nothing and drive rsp_rdata = 0 with rsp_fault = 1.
REQ-023 SHALL commit stores on the RESP edge, updating only the addressed byte lanes: sb writes 1 lane at addr[1:0], sh writes 2 lanes at addr[1], sw writes 4 lanes.
REQ-024 SHALL return load data little-endian from the addressed lanes: lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified.
REQ-025 SHALL drive rsp_rdata = 0 for stores.
REQ-026 SHALL drive rsp_rdata = 0 and rsp_fault = 0 whenever rsp_valid = 0.
REQ-027 SHALL let a load issued in the cycle after a store's RESP observe the stored data.

Reset
REQ-028 SHALL, with reset high at a clock edge, enter IDLE, clear the wait counter, and drive rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0, req_ready = 1 from the next cycle.
REQ-029 SHALL abandon an in-flight request on reset (any state): no store commit, no rsp_valid.
REQ-030 SHALL NOT clear data-array contents on reset.

Structure
REQ-031 SHALL take funct3 constants (LB..LHU, SB..SW) and the FSM state enum from the shared package riscv_mem_pkg.
REQ-032 SHALL place load lane-select and sign/zero-extension in the combinational sub-module load_ext (inputs: word, addr[1:0], funct3; output: 32-bit result).

Verification
REQ-033 SHALL cover: WAIT_CYCLES=1, sw 0xDEADBEEF to 0x40, then lw 0x40 -> rsp_valid exactly 2 cycles after each accept; rdata 0xDEADBEEF, fault 0.
REQ-034 SHALL cover: after REQ-033, sb 0x7F to 0x41, then lb 0x43 / lbu 0x43 / lh 0x42 / lhu 0x40 -> 0xFFFFFFDE / 0x000000DE / 0xFFFFDEAD / 0x00007FEF.
REQ-035 SHALL cover: lw 0x42, sh 0x45, lb 0x400 (DEPTH_WORDS=256), load funct3=011 -> each fault=1, rdata 0; a following lw 0x40 is unchanged.
REQ-036 SHALL cover: req_valid held high 4 cycles with WAIT_CYCLES=2 -> exactly one accept, req_ready low 3 cycles, single rsp_valid pulse.
REQ-037 SHALL cover: sw 0x11223344 to 0x80, reset asserted in WAIT -> no rsp_valid; req_ready = 1 the cycle after reset; lw 0x80 returns prior contents.
REQ-038 SHALL cover: WAIT_CYCLES=0, back-to-back sw/lw to 0x10 -> 1-cycle latency each, req_ready low exactly one cycle per request, lw returns stored value.
